mem_port_arbiter: RTL

- Shares the single external memory/bus port between instruction fetch (IF) and the data load/store port (DM).
- Sequences one outstanding bus transaction at a time.
- Produces the per-requester active-low stall signals that feed the hazard unit's stall/ack inputs; a low stall freezes the pipeline enables.
- Sits between the fetch/memory pipeline stages and the system bus.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_timeout.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: state encoding,
// grant identifiers, default widths and the arbitration pick helper.
// Optional feature macro used by this slice: ARB_TIMEOUT_EN.
package mem_arb_pkg;

  localparam int DEF_AW   = 32;
  localparam int DEF_DW   = 32;
  localparam int DEF_TO_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_BUSY = 2'b01,
    DM_BUSY = 2'b10
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // Data wins by default; fetch wins right after a data grant when both wait.
  function automatic logic arb_pick(input logic dm_req, input logic if_req,
                                    input logic last_dm);
    return (dm_req && !(last_dm && if_req)) ? GNT_DM : GNT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and system bus signals around the arbiter.
// Optional feature macro affecting bus_err: ARB_TIMEOUT_EN.
//
// Handshake: a requester raises *_req with its fields stable and keeps them
// until the one-cycle *_ack; *_rdata is valid only in the ack cycle. The
// arbiter holds bus_req and all bus_* fields stable until the one-cycle
// bus_ack, with bus_rdata valid alongside bus_ack.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_ack;
  logic [DW-1:0]   if_rdata;
  logic            if_stall_n;

  logic            dm_req;
  logic            dm_we;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW/8-1:0] dm_be;
  logic            dm_ack;
  logic [DW-1:0]   dm_rdata;
  logic            dm_stall_n;

  logic            bus_req;
  logic            bus_we;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_be;
  logic            bus_ack;
  logic [DW-1:0]   bus_rdata;
  logic            bus_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           bus_ack, bus_rdata,
    output if_ack, if_rdata, if_stall_n, dm_ack, dm_rdata, dm_stall_n,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           bus_ack, bus_rdata,
    input  if_ack, if_rdata, if_stall_n, dm_ack, dm_rdata, dm_stall_n,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Bus timeout watchdog: counts busy cycles without bus_ack and flags a
// sticky error. Only built when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_timeout #(
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic bus_ack,
  output logic expire,
  output logic err
);

  // Busy cycle k holds count k-1, so the increment that would reach all-ones
  // happens in busy cycle 2^TO_W-1; that cycle is the terminal one.
  localparam logic [TO_W-1:0] TERM = {TO_W{1'b1}} - 1'b1;

  logic [TO_W-1:0] cnt;
  logic            err_q;

  assign expire = busy & ~bus_ack & ~reset & (cnt == TERM);
  assign err    = err_q | expire;

  // Counter clears outside busy states and advances on every unacked busy cycle.
  always_ff @(posedge clk) begin
    if (reset || !busy) begin
      cnt <= '0;
    end else if (!bus_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Error stays set until reset once a transaction has timed out.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one external bus port between instruction fetch and data access,
// one outstanding transaction at a time, and produces active-low stalls.
// Optional feature macro: ARB_TIMEOUT_EN (bus watchdog with sticky bus_err).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int TO_W = DEF_TO_W
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   io,
  output arb_state_t          state,
  output logic                last_dm
);

  logic            bus_req_q;
  logic            bus_we_q;
  logic [AW-1:0]   bus_addr_q;
  logic [DW-1:0]   bus_wdata_q;
  logic [DW/8-1:0] bus_be_q;

  logic            to_expire;
  logic            err;
  logic            done;
  logic [DW-1:0]   done_rdata;
  logic            if_ack_c;
  logic            dm_ack_c;
  logic [DW-1:0]   if_rdata_c;
  logic [DW-1:0]   dm_rdata_c;

`ifdef ARB_TIMEOUT_EN
  arb_timeout #(.TO_W(TO_W)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .busy    (state != IDLE),
    .bus_ack (io.bus_ack),
    .expire  (to_expire),
    .err     (err)
  );
`else
  logic [TO_W-1:0] unused_to_w;
  assign unused_to_w = '0;
  assign to_expire   = 1'b0;
  assign err         = 1'b0;
`endif

  // A timed-out transaction completes with zero data instead of bus_rdata.
  assign done       = io.bus_ack | to_expire;
  assign done_rdata = io.bus_ack ? io.bus_rdata : '0;

  // Grant in IDLE, hold the bus fields while busy, release on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_dm     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.dm_req || io.if_req) begin
            bus_req_q <= 1'b1;
            if (arb_pick(io.dm_req, io.if_req, last_dm) == GNT_DM) begin
              state       <= DM_BUSY;
              last_dm     <= 1'b1;
              bus_we_q    <= io.dm_we;
              bus_addr_q  <= io.dm_addr;
              bus_wdata_q <= io.dm_wdata;
              bus_be_q    <= io.dm_be;
            end else begin
              state       <= IF_BUSY;
              last_dm     <= 1'b0;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= io.if_addr;
              bus_wdata_q <= '0;
              bus_be_q    <= '1;
            end
          end
        end
        IF_BUSY, DM_BUSY: begin
          if (done) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Route completion to the granted requester only; acks are dropped in reset.
  always_comb begin
    if_ack_c   = 1'b0;
    dm_ack_c   = 1'b0;
    if_rdata_c = '0;
    dm_rdata_c = '0;
    if (!reset && done) begin
      if (state == IF_BUSY) begin
        if_ack_c   = 1'b1;
        if_rdata_c = done_rdata;
      end else if (state == DM_BUSY) begin
        dm_ack_c   = 1'b1;
        dm_rdata_c = done_rdata;
      end
    end
  end

  assign io.if_ack     = if_ack_c;
  assign io.if_rdata   = if_rdata_c;
  assign io.dm_ack     = dm_ack_c;
  assign io.dm_rdata   = dm_rdata_c;
  assign io.if_stall_n = ~(io.if_req & ~if_ack_c);
  assign io.dm_stall_n = ~(io.dm_req & ~dm_ack_c);

  assign io.bus_req   = bus_req_q;
  assign io.bus_we    = bus_we_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wdata = bus_wdata_q;
  assign io.bus_be    = bus_be_q;
  assign io.bus_err   = err;

endmodule
